// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with one-cycle grant latency and registered outputs.
// Optional hold timeout is enabled by defining RR_ARB8_TIMEOUT_EN.
module rr_arb8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] sel;
  logic       rel;

`ifdef RR_ARB8_TIMEOUT_EN
  logic [7:0] cnt;
  logic       cnt_top;
  logic       compete;

  // Timeout arms at the last allowed cycle when someone else is waiting.
  always_comb begin
    cnt_top = (cnt == 8'(HOLD_MAX - 1));
    compete = |(req & ~gnt);
  end

  // Hold counter: zero while idle, saturating count while granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (!cnt_top) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_hold;

  // HOLD_MAX has no role without the timeout.
  assign unused_hold = 8'(HOLD_MAX);
`endif

  // First requester at or after ptr, walking upward modulo 8.
  always_comb begin
    sel = '0;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr + 3'(k)]) sel = ptr + 3'(k);
    end
  end

  // Owner gives up via done, by dropping its request, or by timeout.
  always_comb begin
    rel = done | ~req[gnt_id];
`ifdef RR_ARB8_TIMEOUT_EN
    rel = rel | (cnt_top & compete);
`endif
  end

  // Arbitration state, rotating pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state   <= GRANT;
            gnt_id  <= sel;
            gnt     <= 8'b1 << sel;
            gnt_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= IDLE;
            ptr     <= gnt_id + 3'd1;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8 against a behavioural round-robin model.
// Timeout scenario runs only when RR_ARB8_TIMEOUT_EN is defined.
module tb_rr_arb8;

  localparam int HM = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;

  int checks;
  int failures;

  // Model: owner index or -1, next-search start, hold cycles so far.
  int m_owner;
  int m_ptr;
  int m_cnt;

  rr_arb8 #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .gnt_vld(gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_gnt();
    if (m_owner < 0) return 8'h00;
    return 8'h01 << m_owner;
  endfunction

  function automatic logic [2:0] m_id();
    if (m_owner < 0) return 3'd0;
    return 3'(m_owner);
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void m_step(logic [7:0] r, logic d);
    bit release_now;
    bit others;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_cnt   = 0;
        end
      end
    end else begin
      release_now = d || !r[m_owner];
      others = 1'b0;
      for (int i = 0; i < 8; i++)
        if (i != m_owner && r[i]) others = 1'b1;
`ifdef RR_ARB8_TIMEOUT_EN
      if (m_cnt == HM - 1 && others) release_now = 1'b1;
`endif
      if (release_now) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (m_cnt < HM - 1) begin
        m_cnt++;
      end
    end
  endfunction

  // One clock: model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    m_step(req, done);
    #1;
  endtask

  task automatic reset_dut();
    req   = 8'h00;
    done  = 1'b0;
    rst_n = 1'b0;
    #3;
    m_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    checks++;
    if (gnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_gnt got=%h exp=00", gnt);
    end
    checks++;
    if (gnt_id !== 3'd0) begin
      failures++;
      $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id);
    end
    checks++;
    if (gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt_vld got=%b exp=0", gnt_vld);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    reset_dut();
    req = 8'h01;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL basic_grant got=%h/%0d/%b exp=01/0/1",
               gnt, gnt_id, gnt_vld);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_release got=%h/%b exp=00/0", gnt, gnt_vld);
    end
    // ptr now 1: requester 1 beats requester 0
    req = 8'h03;
    tick();
    checks++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1) begin
      failures++;
      $display("FAIL basic_ptr1 got=%h/%0d exp=02/1", gnt, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    reset_dut();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp = 8'h01 << (i % 8);
      checks++;
      if (gnt !== exp || gnt_id !== 3'(i % 8)) begin
        failures++;
        $display("FAIL rr_grant%0d got=%h/%0d exp=%h/%0d",
                 i, gnt, gnt_id, exp, i % 8);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap%0d got=%h/%b exp=00/0", i, gnt, gnt_vld);
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    req = 8'h40;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 8'h81;
    tick();
    checks++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7) begin
      failures++;
      $display("FAIL wrap_first got=%h/%0d exp=80/7", gnt, gnt_id);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h01 || gnt_id !== 3'd0) begin
      failures++;
      $display("FAIL wrap_second got=%h/%0d exp=01/0", gnt, gnt_id);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    req = 8'h08;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_id !== 3'd3) begin
      failures++;
      $display("FAIL areset_pre got=%h/%0d exp=08/3", gnt, gnt_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_id !== 3'd0) begin
      failures++;
      $display("FAIL areset_drop got=%h/%0d/%b exp=00/0/0",
               gnt, gnt_id, gnt_vld);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h08 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL areset_after got=%h/%b exp=08/1", gnt, gnt_vld);
    end
  endtask

  task automatic test_drop_req();
    reset_dut();
    req = 8'h24;
    tick();
    checks++;
    if (gnt !== 8'h04) begin
      failures++;
      $display("FAIL drop_grant got=%h exp=04", gnt);
    end
    req = 8'h20;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL drop_release got=%h/%b exp=00/0", gnt, gnt_vld);
    end
    tick();
    checks++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
      failures++;
      $display("FAIL drop_next got=%h/%0d exp=20/5", gnt, gnt_id);
    end
  endtask

  task automatic test_done_idle();
    reset_dut();
    done = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL idle_done got=%h/%b exp=00/0", gnt, gnt_vld);
    end
    done = 1'b0;
    req  = 8'h01;
    tick();
    checks++;
    if (gnt !== 8'h01) begin
      failures++;
      $display("FAIL idle_done_ptr got=%h exp=01", gnt);
    end
  endtask

`ifdef RR_ARB8_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp [6];
    exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02};
    reset_dut();
    req = 8'h03;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (gnt !== exp[i]) begin
        failures++;
        $display("FAIL timeout_c%0d got=%h exp=%h", i, gnt, exp[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int ones;
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if (gnt !== m_gnt() || gnt_id !== m_id() ||
          gnt_vld !== (m_owner >= 0)) begin
        failures++;
        $display("FAIL rand_c%0d got=%h/%0d/%b exp=%h/%0d/%b", n,
                 gnt, gnt_id, gnt_vld, m_gnt(), m_id(), m_owner >= 0);
      end
      ones = $countones(gnt);
      checks++;
      if (ones > 1 || (gnt_vld && gnt !== (8'h01 << gnt_id))) begin
        failures++;
        $display("FAIL rand_onehot%0d got=%h id=%0d exp=onehot",
                 n, gnt, gnt_id);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    done     = 1'b0;
    m_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_async_reset();
    test_drop_req();
    test_done_idle();
`ifdef RR_ARB8_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum GRANT-state cycles before a forced release (used only with RR_ARB8_TIMEOUT_EN); legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request vector; req[i] high = requester i wants the shared resource.
REQ-005 done  input  1  single-cycle release pulse from the current owner; ignored outside GRANT.
REQ-006 gnt  output  8  one-hot grant; bit gnt_id set when gnt_vld=1, else all zero.
REQ-007 gnt_id  output  3  encoded index of the current owner; 0 when gnt_vld=0.
REQ-008 gnt_vld  output  1  high while a grant is active.

Function
REQ-009 Two states: IDLE and GRANT; all outputs registered.
REQ-010 IDLE, any req bit set: select the first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8). On the next edge, load gnt_id, set gnt_vld, drive gnt as the 3-to-8 one-hot decode of gnt_id, and enter GRANT.
REQ-011 IDLE, req==0: remain in IDLE with outputs zero.
REQ-012 Grant latency: req sampled at edge N in IDLE -> gnt valid after edge N; one-cycle latency.
REQ-013 GRANT: hold gnt_id unchanged, regardless of other req bits, until a release event.
REQ-014 Release event: done=1, or req[gnt_id]=0, sampled at an edge.
REQ-015 On release: clear gnt/gnt_vld/gnt_id, set ptr = gnt_id+1 mod 8 (7 wraps to 0), and enter IDLE.
REQ-016 A released requester therefore has lowest priority in the next arbitration.
REQ-017 Minimum one IDLE cycle (gnt=0) between consecutive grants; no back-to-back grant without a gap.
REQ-018 done asserted in IDLE has no effect.
REQ-019 done and req[gnt_id] drop in the same cycle count as one release.
REQ-020 Invariant: gnt is always zero or exactly one-hot; gnt equals the one-hot decode of gnt_id whenever gnt_vld=1.

Reset
REQ-021 rst_n low asynchronously forces: state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_vld=0, hold counter=0.
REQ-022 Reset asserted mid-GRANT drops the grant immediately without waiting for a clock edge.
REQ-023 After reset release, the first arbitration starts from ptr=0.

Configuration
REQ-024 Macro RR_ARB8_TIMEOUT_EN defined: an 8-bit hold counter clears on GRANT entry and increments each GRANT cycle.
REQ-025 With RR_ARB8_TIMEOUT_EN: when counter==HOLD_MAX-1 and any req bit other than req[gnt_id] is set, a forced release occurs at that edge (same effects as REQ-015).
REQ-026 With RR_ARB8_TIMEOUT_EN: with no competing request, the counter saturates at HOLD_MAX-1 and the grant is held.
REQ-027 Without RR_ARB8_TIMEOUT_EN: no counter logic exists, HOLD_MAX is unused, and a grant is held indefinitely until REQ-014.

Verification
REQ-028 Reset, then req=8'h01 -> next cycle gnt=8'h01, gnt_id=0, gnt_vld=1; pulse done -> next cycle gnt=0 and ptr=1.
REQ-029 req=8'hFF held, owner releases via done each grant -> grant order 0,1,...,7,0, with one gap cycle between grants.
REQ-030 ptr=7, req=8'h81 -> gnt=8'h80; on release -> next grant gnt=8'h01 (wrap-around).
REQ-031 Mid-GRANT (gnt_id=3), drive rst_n low between clock edges -> gnt=0, gnt_vld=0 immediately; after reset release with req=8'h08 -> gnt=8'h08.
REQ-032 TIMEOUT_EN, HOLD_MAX=4, req=8'h03, done never asserted -> gnt=8'h01 for 4 cycles, 1 gap cycle, then gnt=8'h02.
REQ-033 Owner drops req[gnt_id] with done=0 -> release next edge; random req/done stimulus -> gnt always zero or one-hot.
